// File: rtl/bus_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// bus_sequencer_pkg
//  Shared definitions for the bus micro-op sequencer: opcode and state
//  encodings, strobe bit positions for en_reg/tri_reg, the command layout
//  and a helper that turns a 3-bit register index into a strobe bit.
// -----------------------------------------------------------------------------
package bus_sequencer_pkg;

  localparam int NREG  = 8;
  localparam int CMD_W = 8;
  localparam int EN_W  = 12;

  typedef enum logic [1:0] {
    OP_MV  = 2'b00,
    OP_LDI = 2'b01,
    OP_ADD = 2'b10,
    OP_XOR = 2'b11
  } op_e;

  // en_reg bit positions above the general registers
  localparam int EN_A = 11;
  localparam int EN_G = 10;
  localparam int EN_B = 9;
  localparam int EN_H = 8;

  // tri_reg bit positions above the general registers
  localparam int TRI_IMM = 8;
  localparam int TRI_H   = 9;
  localparam int TRI_G   = 10;
  localparam int TRI_PC  = 11;  // owned by cpu_fsm, never driven here

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    S1   = 2'b01,
    S2   = 2'b10,
    S3   = 2'b11
  } state_e;

  typedef struct packed {
    op_e        op;
    logic [2:0] rx;
    logic [2:0] ry;
  } cmd_t;

  // One-hot strobe vector selecting general register idx (bits [7:0]).
  function automatic logic [EN_W-1:0] reg_bit(input logic [2:0] idx);
    logic [EN_W-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/bus_sequencer_if.sv
// -----------------------------------------------------------------------------
// bus_sequencer_if
//  Requester handshake plus datapath strobe bundle of the bus sequencer.
//  master : requesters/datapath side (drives req, cmd0, cmd1)
//  slave  : sequencer side (drives gnt, done, busy, en_reg, tri_reg)
//  Signals:
//   req[1:0]      level request per requester, held until its gnt
//   cmd0/cmd1     {op[1:0], rx[2:0], ry[2:0]} per requester
//   gnt[1:0]      one-cycle pulse when that requester's command is latched
//   done[1:0]     one-cycle pulse in the last micro-op cycle of that command
//   busy          sequencer not in IDLE
//   en_reg        latch enables, tri_reg bus driver enables
// -----------------------------------------------------------------------------
interface bus_sequencer_if;
  import bus_sequencer_pkg::*;

  logic [1:0]       req;
  logic [CMD_W-1:0] cmd0;
  logic [CMD_W-1:0] cmd1;
  logic [1:0]       gnt;
  logic [1:0]       done;
  logic             busy;
  logic [EN_W-1:0]  en_reg;
  logic [EN_W-1:0]  tri_reg;

  modport master (
    output req, cmd0, cmd1,
    input  gnt, done, busy, en_reg, tri_reg
  );

  modport slave (
    input  req, cmd0, cmd1,
    output gnt, done, busy, en_reg, tri_reg
  );

endinterface

// File: rtl/bus_sequencer_rr_arbiter2.sv
// -----------------------------------------------------------------------------
// rr_arbiter2
//  Two-way round-robin arbiter. A lone request always wins; on a tie the
//  requester that was not granted last wins. The last-grant pointer moves
//  only when advance_i is high and some request is present.
//  Ports:
//   clk        clock
//   rst        synchronous active-low reset (requester 0 wins the next tie)
//   req_i[1:0] requests
//   advance_i  a grant is being taken this cycle
//   gnt_o[1:0] one-hot (or zero) grant, combinational from req_i
// -----------------------------------------------------------------------------
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       advance_i,
  output logic [1:0] gnt_o
);

  // 1: requester 1 was granted last, so requester 0 wins a tie.
  logic last_q;

  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      last_q <= 1'b1;
    end else if (advance_i && (req_i != 2'b00)) begin
      last_q <= gnt_o[1];
    end
  end

endmodule

// File: rtl/bus_sequencer.sv
// -----------------------------------------------------------------------------
// bus_sequencer
//  Arbitrates macro commands from two requesters and sequences them into
//  per-cycle latch-enable (en_reg) and bus-driver (tri_reg) strobes for the
//  shared 16-bit datapath. At most one bus driver is enabled per cycle.
//  Ports:
//   clk   clock, all state on the rising edge
//   rst   synchronous active-low reset; aborts any command in flight
//   bus   bus_sequencer_if.slave (req/cmd in, gnt/done/busy/strobes out)
//  Sequencing (after the IDLE grant cycle):
//   MV/LDI : S1 (write Rx, done)
//   ADD    : S1 Rx->A, S2 Ry->G(=A+bus), S3 G->Rx done
//   XOR    : S1 Rx->B, S2 Ry->H(=B^bus), S3 H->Rx done
// -----------------------------------------------------------------------------
module bus_sequencer
  import bus_sequencer_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  bus_sequencer_if.slave  bus
);

  state_e     state_q;
  cmd_t       cmd_q;
  logic       owner_q;

  logic [1:0] arb_gnt;
  logic       take_grant;
  cmd_t       cmd_d;

  assign take_grant = (state_q == IDLE);

  rr_arbiter2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .req_i     (bus.req),
    .advance_i (take_grant),
    .gnt_o     (arb_gnt)
  );

  // Command of the winning requester, latched on the grant cycle.
  assign cmd_d = arb_gnt[1] ? cmd_t'(bus.cmd1) : cmd_t'(bus.cmd0);

  // The grant is the only output that looks at inputs directly; it is masked
  // while reset is asserted so no requester sees a grant that gets discarded.
  assign bus.gnt  = (take_grant && rst) ? arb_gnt : 2'b00;
  assign bus.busy = (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      owner_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req != 2'b00) begin
            cmd_q   <= cmd_d;
            owner_q <= arb_gnt[1];
            state_q <= S1;
          end
        end
        S1: begin
          if ((cmd_q.op == OP_ADD) || (cmd_q.op == OP_XOR)) begin
            state_q <= S2;
          end else begin
            state_q <= IDLE;
          end
        end
        S2:      state_q <= S3;
        S3:      state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Moore strobe decode: depends only on state and the latched command.
  logic [EN_W-1:0] en_d;
  logic [EN_W-1:0] tri_d;
  logic            fin_d;

  always_comb begin
    en_d  = '0;
    tri_d = '0;
    fin_d = 1'b0;
    case (state_q)
      S1: begin
        case (cmd_q.op)
          OP_MV: begin
            tri_d = reg_bit(cmd_q.ry);
            en_d  = reg_bit(cmd_q.rx);
            fin_d = 1'b1;
          end
          OP_LDI: begin
            tri_d[TRI_IMM] = 1'b1;
            en_d           = reg_bit(cmd_q.rx);
            fin_d          = 1'b1;
          end
          OP_ADD: begin
            tri_d      = reg_bit(cmd_q.rx);
            en_d[EN_A] = 1'b1;
          end
          OP_XOR: begin
            tri_d      = reg_bit(cmd_q.rx);
            en_d[EN_B] = 1'b1;
          end
          default: ;
        endcase
      end
      S2: begin
        tri_d = reg_bit(cmd_q.ry);
        if (cmd_q.op == OP_ADD) begin
          en_d[EN_G] = 1'b1;
        end else begin
          en_d[EN_H] = 1'b1;
        end
      end
      S3: begin
        if (cmd_q.op == OP_ADD) begin
          tri_d[TRI_G] = 1'b1;
        end else begin
          tri_d[TRI_H] = 1'b1;
        end
        en_d  = reg_bit(cmd_q.rx);
        fin_d = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.en_reg  = en_d;
  assign bus.tri_reg = tri_d;
  assign bus.done    = fin_d ? (owner_q ? 2'b10 : 2'b01) : 2'b00;

endmodule

// File: tb/tb_bus_sequencer.sv
// -----------------------------------------------------------------------------
// tb_bus_sequencer
//  Directed bench for bus_sequencer. A transaction-level model turns each
//  grant into the list of per-cycle strobes the op table demands, and a
//  negedge compare process checks every cycle against it. A small register
//  file driven by the DUT strobes confirms the arithmetic results.
// -----------------------------------------------------------------------------
module tb_bus_sequencer;
  import bus_sequencer_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  bus_sequencer_if bif ();

  bus_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cyc_n  = 0;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  // ---------------- datapath driven by DUT strobes ----------------
  logic [15:0] dp [8] = '{16'h0000, 16'h1111, 16'h0000, 16'h0222,
                          16'h0444, 16'h0555, 16'h0000, 16'h0000};
  logic [15:0] a_r = '0, b_r = '0, g_r = '0, h_r = '0;
  logic [15:0] imm_v = 16'h0005;
  logic [15:0] bus_v;

  always_comb begin
    bus_v = '0;
    for (int i = 0; i < 8; i++) if (bif.tri_reg[i] === 1'b1) bus_v = dp[i];
    if (bif.tri_reg[TRI_IMM] === 1'b1) bus_v = imm_v;
    if (bif.tri_reg[TRI_H] === 1'b1)   bus_v = h_r;
    if (bif.tri_reg[TRI_G] === 1'b1)   bus_v = g_r;
  end

  always @(posedge clk) begin
    for (int i = 0; i < 8; i++) if (bif.en_reg[i] === 1'b1) dp[i] <= bus_v;
    if (bif.en_reg[EN_A] === 1'b1) a_r <= bus_v;
    if (bif.en_reg[EN_B] === 1'b1) b_r <= bus_v;
    if (bif.en_reg[EN_G] === 1'b1) g_r <= a_r + bus_v;
    if (bif.en_reg[EN_H] === 1'b1) h_r <= b_r ^ bus_v;
  end

  // ---------------- transaction-level model ----------------
  typedef struct packed {
    logic [1:0]  gnt;
    logic [1:0]  done;
    logic [11:0] en;
    logic [11:0] tr;
  } exp_t;

  exp_t mq[$];
  int   last_m   = 1;
  logic rst_seen = 1'b0;

  function automatic exp_t mk(input logic [11:0] tr, input logic [11:0] en, input logic [1:0] dn);
    exp_t e;
    e.gnt = 2'b00; e.done = dn; e.en = en; e.tr = tr;
    return e;
  endfunction

  // Expand one command into the cycles that follow its grant.
  task automatic push_ops(input logic [7:0] c, input logic [1:0] who);
    logic [11:0] bx, by;
    bx = 12'h001 << c[5:3];
    by = 12'h001 << c[2:0];
    case (c[7:6])
      2'b00: mq.push_back(mk(by, bx, who));
      2'b01: mq.push_back(mk(12'h100, bx, who));
      2'b10: begin
        mq.push_back(mk(bx, 12'h800, 2'b00));
        mq.push_back(mk(by, 12'h400, 2'b00));
        mq.push_back(mk(12'h400, bx, who));
      end
      default: begin
        mq.push_back(mk(bx, 12'h200, 2'b00));
        mq.push_back(mk(by, 12'h100, 2'b00));
        mq.push_back(mk(12'h200, bx, who));
      end
    endcase
  endtask

  always @(posedge clk) if (!rst) rst_seen <= 1'b1;

  exp_t       e;
  logic       busy_e;
  int         w;
  logic [7:0] c_m;

  always @(negedge clk) begin
    if (rst_seen) begin
      e      = '0;
      busy_e = 1'b0;
      if (mq.size() != 0) begin
        e      = mq.pop_front();
        busy_e = 1'b1;
      end else if (rst && bif.req != 2'b00) begin
        if (bif.req == 2'b11) w = (last_m == 1) ? 0 : 1;
        else                  w = bif.req[1] ? 1 : 0;
        last_m = w;
        e.gnt  = (w == 1) ? 2'b10 : 2'b01;
        c_m    = (w == 1) ? bif.cmd1 : bif.cmd0;
        push_ops(c_m, e.gnt);
        $display("grant port%0d cmd=%h cycle %0d", w, c_m, cyc_n);
      end
      chk("gnt",  {14'b0, bif.gnt},  {14'b0, e.gnt});
      chk("done", {14'b0, bif.done}, {14'b0, e.done});
      chk("busy", {15'b0, bif.busy}, {15'b0, busy_e});
      chk("en_reg",  {4'b0, bif.en_reg},  {4'b0, e.en});
      chk("tri_reg", {4'b0, bif.tri_reg}, {4'b0, e.tr});
      chk("tri_onehot0", {15'b0, $onehot0(bif.tri_reg)}, 16'd1);
      chk("en_lo_onehot0", {15'b0, $onehot0(bif.en_reg[7:0])}, 16'd1);
      chk("tri_pc_idle", {15'b0, bif.tri_reg[TRI_PC]}, 16'd0);
      if (!rst) begin
        mq.delete();
        last_m = 1;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    repeat (5) step();
  endtask

  task automatic wait_gnt(input logic [1:0] exp, input string name);
    int t;
    t = 0;
    @(negedge clk);
    while (bif.gnt == 2'b00 && t < 10) begin
      @(negedge clk);
      t++;
    end
    chk(name, {14'b0, bif.gnt}, {14'b0, exp});
  endtask

  logic [1:0] t4_exp [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
  int         prev_g;

  initial begin
    bif.req  = 2'b11;
    bif.cmd0 = 8'h01;   // MV R0<-R1
    bif.cmd1 = 8'h08;   // MV R1<-R0

    // 1) reset with both requests pending
    step(); step();
    @(negedge clk);
    chk("t1_gnt",  {14'b0, bif.gnt}, 16'h0);
    chk("t1_done", {14'b0, bif.done}, 16'h0);
    chk("t1_busy", {15'b0, bif.busy}, 16'h0);
    chk("t1_en",   {4'b0, bif.en_reg}, 16'h0);
    chk("t1_tri",  {4'b0, bif.tri_reg}, 16'h0);
    step(); rst = 1'b1;
    @(negedge clk);
    chk("t1_first_gnt", {14'b0, bif.gnt}, 16'h0001);
    step(); bif.req = 2'b00;
    settle();

    // 2) MV R2<-R5 from port 0
    bif.cmd0 = 8'h15; bif.req = 2'b01;
    wait_gnt(2'b01, "t2_gnt");
    step(); bif.req = 2'b00;
    @(negedge clk);
    chk("t2_tri",  {4'b0, bif.tri_reg}, 16'h0020);
    chk("t2_en",   {4'b0, bif.en_reg},  16'h0004);
    chk("t2_done", {14'b0, bif.done},   16'h0001);
    step();
    @(negedge clk);
    chk("t2_idle", {15'b0, bif.busy}, 16'h0);
    chk("t2_r2", dp[2], 16'h0555);
    settle();

    // 3) ADD R1,R3 from port 1
    bif.cmd1 = 8'h8B; bif.req = 2'b10;
    wait_gnt(2'b10, "t3_gnt");
    step(); bif.req = 2'b00;
    @(negedge clk);
    chk("t3_s1_tri", {4'b0, bif.tri_reg}, 16'h0002);
    chk("t3_s1_en",  {4'b0, bif.en_reg},  16'h0800);
    step(); @(negedge clk);
    chk("t3_s2_tri", {4'b0, bif.tri_reg}, 16'h0008);
    chk("t3_s2_en",  {4'b0, bif.en_reg},  16'h0400);
    step(); @(negedge clk);
    chk("t3_s3_tri",  {4'b0, bif.tri_reg}, 16'h0400);
    chk("t3_s3_en",   {4'b0, bif.en_reg},  16'h0002);
    chk("t3_s3_done", {14'b0, bif.done},   16'h0002);
    step(); @(negedge clk);
    chk("t3_r1", dp[1], 16'h1333);
    settle();

    // 4) both requesters held over four MV commands
    bif.cmd0 = 8'h30; bif.cmd1 = 8'h38; bif.req = 2'b11;
    prev_g = 0;
    for (int k = 0; k < 4; k++) begin
      wait_gnt(t4_exp[k], "t4_order");
      if (k > 0) chk("t4_spacing", 16'(cyc_n - prev_g), 16'd2);
      prev_g = cyc_n;
      step();
    end
    bif.req = 2'b00;
    settle();
    chk("t4_r6", dp[6], 16'h1111);
    chk("t4_r7", dp[7], 16'h1111);

    // 5) XOR R4,R4 then LDI R4
    bif.cmd0 = 8'hE4; bif.req = 2'b01;
    wait_gnt(2'b01, "t5_xor_gnt");
    step(); bif.req = 2'b00;
    settle();
    chk("t5_r4_zero", dp[4], 16'h0000);
    bif.cmd0 = 8'h60; bif.req = 2'b01;
    wait_gnt(2'b01, "t5_ldi_gnt");
    step(); bif.req = 2'b00;
    settle();
    chk("t5_r4_imm", dp[4], 16'h0005);

    // 6) reset during S2 of ADD R5,R6 from port 0
    bif.cmd0 = 8'hAE; bif.req = 2'b01;
    wait_gnt(2'b01, "t6_gnt");
    step(); bif.req = 2'b00;          // S1
    step(); rst = 1'b0;               // S2 with reset asserted
    @(negedge clk);
    chk("t6_s2_tri", {4'b0, bif.tri_reg}, 16'h0040);
    chk("t6_s2_en",  {4'b0, bif.en_reg},  16'h0400);
    step(); rst = 1'b1;
    @(negedge clk);
    chk("t6_busy", {15'b0, bif.busy}, 16'h0);
    chk("t6_en",   {4'b0, bif.en_reg}, 16'h0);
    chk("t6_tri",  {4'b0, bif.tri_reg}, 16'h0);
    chk("t6_done", {14'b0, bif.done}, 16'h0);
    step(); step(); step();
    chk("t6_r5", dp[5], 16'h0555);
    // pointer back to favour requester 0 after reset
    bif.cmd0 = 8'h01; bif.cmd1 = 8'h08; bif.req = 2'b11;
    wait_gnt(2'b01, "t6_ptr_reset");
    step(); bif.req = 2'b00;
    settle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
